// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared constants for the fetch unit and core
//
// Purpose: FSM state encodings, fetch fill instructions and ALU op codes
//          shared between the instruction fetch unit and the core.
// Ports:   none (package).
package ifu_fetch_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;

  localparam logic [31:0] C_RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] C_NOP_INST  = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] C_EBRK_INST = 32'h0010_0073;  // ebreak

  // Core ALU operation codes
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // Low address bits of a fetch target; non-zero means not word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_linebuf.sv
// rtl/ifu_linebuf.sv - one-entry instruction line buffer with hit compare
//
// Purpose: remembers the last successfully fetched {tag, data} so a reload
//          of the same pc can skip the memory round trip.
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset, clears valid
//   fill_i         write tag/data and set valid
//   fill_tag_i     address of the fetched word
//   fill_data_i    fetched word
//   flush_i        clear valid (fence.i); wins over a same-cycle fill
//   lookup_tag_i   address being looked up
//   hit_o          valid entry whose tag matches lookup_tag_i
//   data_o         stored word
module ifu_linebuf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fill_i,
  input  logic [31:0] fill_tag_i,
  input  logic [31:0] fill_data_i,
  input  logic        flush_i,
  input  logic [31:0] lookup_tag_i,
  output logic        hit_o,
  output logic [31:0] data_o
);

  logic        vld_q;
  logic [31:0] tag_q;
  logic [31:0] data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else if (flush_i) begin
      // A fill racing a fence.i may carry pre-fence code; drop it.
      vld_q <= 1'b0;
    end else if (fill_i) begin
      vld_q  <= 1'b1;
      tag_q  <= fill_tag_i;
      data_q <= fill_data_i;
    end
  end

  assign hit_o  = vld_q && (tag_q == lookup_tag_i);
  assign data_o = data_q;

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit feeding the single-cycle core
//
// Purpose: holds the fetch pc, issues one imem read per instruction over a
//          valid/ready request + valid response channel, and presents a
//          stable cmd/pc pair with cmd_valid until the core retires it.
// Optional feature: define IFU_LINEBUF_EN to add a one-entry line buffer
//          (ifu_linebuf) giving 1-cycle reloads of the last fetched pc.
// Ports:
//   clk, rst                     clock / asynchronous active-high reset
//   pc_next, pc_load             core dnpc and retire strobe
//   flush                        fence.i buffer invalidate (linebuf build only)
//   pc, cmd, cmd_valid           fetched instruction and its address
//   fetch_err                    cmd is ebreak due to misalign or access fault
//   imem_req_valid/ready/addr    read request channel
//   imem_resp_valid/data/err     read response channel
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = C_RESET_PC,
  parameter logic [31:0] NOP_INST  = C_NOP_INST,
  parameter logic [31:0] EBRK_INST = C_EBRK_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  input  logic        pc_load,
  input  logic        flush,
  output logic [31:0] pc,
  output logic [31:0] cmd,
  output logic        cmd_valid,
  output logic        fetch_err,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err
);

  ifu_state_e  state_q;
  logic [31:0] pc_q;
  logic [31:0] cmd_q;
  logic        cmd_valid_q;
  logic        fetch_err_q;

  logic        lb_hit;
  logic [31:0] lb_data;

`ifdef IFU_LINEBUF_EN
  logic lb_raw_hit;

  ifu_linebuf u_linebuf (
    .clk_i        (clk),
    .rst_i        (rst),
    .fill_i       (state_q == S_WAIT && imem_resp_valid && !imem_resp_err),
    .fill_tag_i   (pc_q),
    .fill_data_i  (imem_resp_data),
    .flush_i      (flush),
    .lookup_tag_i (pc_next),
    .hit_o        (lb_raw_hit),
    .data_o       (lb_data)
  );

  // flush coinciding with pc_load forces a real fetch
  assign lb_hit = lb_raw_hit && !flush;
`else
  logic unused_flush;

  assign unused_flush = flush;
  assign lb_hit       = 1'b0;
  assign lb_data      = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      cmd_q       <= NOP_INST;
      cmd_valid_q <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_req_ready) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            cmd_q       <= imem_resp_err ? EBRK_INST : imem_resp_data;
            fetch_err_q <= imem_resp_err;
            cmd_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (pc_load) begin
            pc_q <= pc_next;
            if (is_misaligned(pc_next[1:0])) begin
              // Never put a misaligned address on the bus; fault locally.
              cmd_q       <= EBRK_INST;
              fetch_err_q <= 1'b1;
              cmd_valid_q <= 1'b1;
            end else if (lb_hit) begin
              cmd_q       <= lb_data;
              fetch_err_q <= 1'b0;
              cmd_valid_q <= 1'b1;
            end else begin
              cmd_q       <= NOP_INST;
              fetch_err_q <= 1'b0;
              cmd_valid_q <= 1'b0;
              state_q     <= S_REQ;
            end
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  // Request valid is decoded from state but must not leak out during reset.
  assign imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem_req_addr  = {pc_q[31:2], 2'b00};

  assign pc        = pc_q;
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_next;
  logic        pc_load;
  logic        flush;
  logic [31:0] pc;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic        fetch_err;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;

  ifu_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .pc_next         (pc_next),
    .pc_load         (pc_load),
    .flush           (flush),
    .pc              (pc),
    .cmd             (cmd),
    .cmd_valid       (cmd_valid),
    .fetch_err       (fetch_err),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cmd;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] acc_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          req_count = 0;
  logic        resp_hold = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFC;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0297;
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory model: records accepted addresses, answers one cycle after accept.
  initial begin : responder
    logic        acc;
    logic [31:0] a;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_resp_err   = 1'b0;
    forever begin
      @(negedge clk);
      acc = imem_req_valid && imem_req_ready && !rst;
      a   = imem_req_addr;
      if (acc) begin
        req_count++;
        acc_q.push_back(a);
      end
      @(posedge clk);
      #1;
      if (acc && !resp_hold && !rst) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_data(a);
        imem_resp_err   = (a == err_addr);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Drive one pc_load cycle and push the expected result to the scoreboard.
  task automatic do_load(input logic [31:0] a, input logic with_flush);
    exp_t e;
    @(posedge clk);
    #1;
    pc_load = 1'b1;
    pc_next = a;
    flush   = with_flush;
    e.pc    = a;
    if (a[1:0] != 2'b00 || a == err_addr) begin
      e.cmd = EBRK;
      e.err = 1'b1;
    end else begin
      e.cmd = mem_data(a);
      e.err = 1'b0;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pc_load = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int          cyc;
    exp_t        e;
    logic [31:0] got;
    rst = 1'b1; pc_load = 1'b0; flush = 1'b0; pc_next = '0; imem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({imem_req_valid, cmd_valid, fetch_err} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got req/valid/err=%b want 000", {imem_req_valid, cmd_valid, fetch_err});
    end
    n_cmp++;
    if (pc !== 32'h8000_0000) begin n_bad++; $display("FAIL reset_pc: got %h want 80000000", pc); end
    n_cmp++;
    if (cmd !== NOP) begin n_bad++; $display("FAIL reset_cmd: got %h want %h", cmd, NOP); end
    exp_q.push_back('{pc: 32'h8000_0000, cmd: 32'h0000_0297, err: 1'b0});
    rst = 1'b0;
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 3) begin n_bad++; $display("FAIL reset_first_latency: got %0d want 3", cyc); end
    e = exp_q.pop_front();
    n_cmp++;
    if ({pc, cmd, fetch_err} !== {e.pc, e.cmd, e.err}) begin
      n_bad++; $display("FAIL reset_first_fetch: got pc=%h cmd=%h err=%b want pc=%h cmd=%h err=%b", pc, cmd, fetch_err, e.pc, e.cmd, e.err);
    end
    got = (acc_q.size() > 0) ? acc_q.pop_front() : 32'hDEAD_DEAD;
    n_cmp++;
    if (got !== 32'h8000_0000) begin n_bad++; $display("FAIL reset_req_addr: got %h want 80000000", got); end
  endtask

  task automatic test_ready_stall();
    int          cyc;
    int          rc;
    exp_t        e;
    logic [31:0] got;
    rc = req_count;
    imem_req_ready = 1'b0;
    do_load(32'h8000_0008, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({imem_req_valid, imem_req_addr, cmd_valid} !== {1'b1, 32'h8000_0008, 1'b0}) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got valid=%b addr=%h cmd_valid=%b want 1 80000008 0", i, imem_req_valid, imem_req_addr, cmd_valid);
      end
    end
    @(posedge clk);
    #1;
    imem_req_ready = 1'b1;
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 3) begin n_bad++; $display("FAIL stall_latency: got %0d want 3", cyc); end
    e = exp_q.pop_front();
    n_cmp++;
    if ({pc, cmd, fetch_err} !== {e.pc, e.cmd, e.err}) begin
      n_bad++; $display("FAIL stall_fetch: got pc=%h cmd=%h err=%b want pc=%h cmd=%h err=%b", pc, cmd, fetch_err, e.pc, e.cmd, e.err);
    end
    got = (acc_q.size() > 0) ? acc_q.pop_front() : 32'hDEAD_DEAD;
    n_cmp++;
    if (got !== 32'h8000_0008 || req_count - rc !== 1) begin
      n_bad++; $display("FAIL stall_req: got addr=%h reqs=%0d want 80000008 1", got, req_count - rc);
    end
  endtask

  task automatic test_misaligned();
    int   cyc;
    int   rc;
    exp_t e;
    rc = req_count;
    do_load(32'h8000_0006, 1'b0);
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 1) begin n_bad++; $display("FAIL misalign_latency: got %0d want 1", cyc); end
    e = exp_q.pop_front();
    n_cmp++;
    if ({pc, cmd, fetch_err} !== {e.pc, e.cmd, e.err}) begin
      n_bad++; $display("FAIL misalign_fetch: got pc=%h cmd=%h err=%b want pc=%h cmd=%h err=%b", pc, cmd, fetch_err, e.pc, e.cmd, e.err);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (req_count - rc !== 0 || cmd_valid !== 1'b1) begin
      n_bad++; $display("FAIL misalign_noreq: got reqs=%0d cmd_valid=%b want 0 1", req_count - rc, cmd_valid);
    end
  endtask

  task automatic test_resp_err();
    int          cyc;
    exp_t        e;
    logic [31:0] got;
    err_addr = 32'h8000_0010;
    do_load(32'h8000_0010, 1'b0);
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 3) begin n_bad++; $display("FAIL resp_err_latency: got %0d want 3", cyc); end
    e = exp_q.pop_front();
    n_cmp++;
    if ({pc, cmd, fetch_err} !== {e.pc, e.cmd, e.err}) begin
      n_bad++; $display("FAIL resp_err_fetch: got pc=%h cmd=%h err=%b want pc=%h cmd=%h err=%b", pc, cmd, fetch_err, e.pc, e.cmd, e.err);
    end
    got = (acc_q.size() > 0) ? acc_q.pop_front() : 32'hDEAD_DEAD;
    n_cmp++;
    if (got !== 32'h8000_0010) begin n_bad++; $display("FAIL resp_err_req: got %h want 80000010", got); end
    do_load(32'h8000_0014, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({fetch_err, cmd_valid, cmd} !== {1'b0, 1'b0, NOP}) begin
      n_bad++; $display("FAIL err_clear: got err=%b valid=%b cmd=%h want 0 0 %h", fetch_err, cmd_valid, cmd, NOP);
    end
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 2) begin n_bad++; $display("FAIL err_clear_latency: got %0d want 2", cyc); end
    e = exp_q.pop_front();
    n_cmp++;
    if ({pc, cmd, fetch_err} !== {e.pc, e.cmd, e.err}) begin
      n_bad++; $display("FAIL err_clear_fetch: got pc=%h cmd=%h err=%b want pc=%h cmd=%h err=%b", pc, cmd, fetch_err, e.pc, e.cmd, e.err);
    end
    void'(acc_q.pop_front());
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs[5];
    int          cyc;
    int          want_lat;
    exp_t        e;
    logic [31:0] got;
    addrs = '{32'h8000_0100, 32'h8000_0104, 32'h8000_1001, 32'h8000_1000, 32'h8000_0FFC};
    for (int i = 0; i < 5; i++) begin
      do_load(addrs[i], 1'b0);
      want_lat = (addrs[i][1:0] != 2'b00) ? 1 : 3;
      wait_valid(cyc);
      n_cmp++;
      if (cyc !== want_lat) begin n_bad++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, cyc, want_lat); end
      e = exp_q.pop_front();
      n_cmp++;
      if ({pc, cmd, fetch_err} !== {e.pc, e.cmd, e.err}) begin
        n_bad++; $display("FAIL b2b_fetch[%0d]: got pc=%h cmd=%h err=%b want pc=%h cmd=%h err=%b", i, pc, cmd, fetch_err, e.pc, e.cmd, e.err);
      end
      if (want_lat == 3) begin
        got = (acc_q.size() > 0) ? acc_q.pop_front() : 32'hDEAD_DEAD;
        n_cmp++;
        if (got !== addrs[i]) begin n_bad++; $display("FAIL b2b_req[%0d]: got %h want %h", i, got, addrs[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int          cyc;
    exp_t        e;
    logic [31:0] got;
    resp_hold = 1'b1;
    do_load(32'h8000_0030, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({imem_req_valid, cmd_valid} !== 2'b00) begin
      n_bad++; $display("FAIL midwait_state: got req=%b valid=%b want 0 0", imem_req_valid, cmd_valid);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({pc, cmd, cmd_valid, fetch_err, imem_req_valid} !== {32'h8000_0000, NOP, 3'b000}) begin
      n_bad++; $display("FAIL midwait_reset: got pc=%h cmd=%h valid=%b err=%b req=%b want 80000000 %h 0 0 0", pc, cmd, cmd_valid, fetch_err, imem_req_valid, NOP);
    end
    exp_q.delete();
    got = (acc_q.size() > 0) ? acc_q.pop_front() : 32'hDEAD_DEAD;
    n_cmp++;
    if (got !== 32'h8000_0030) begin n_bad++; $display("FAIL midwait_req: got %h want 80000030", got); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_hold = 1'b0;
    exp_q.push_back('{pc: 32'h8000_0000, cmd: 32'h0000_0297, err: 1'b0});
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 3) begin n_bad++; $display("FAIL refetch_latency: got %0d want 3", cyc); end
    e = exp_q.pop_front();
    n_cmp++;
    if ({pc, cmd, fetch_err} !== {e.pc, e.cmd, e.err}) begin
      n_bad++; $display("FAIL refetch: got pc=%h cmd=%h err=%b want pc=%h cmd=%h err=%b", pc, cmd, fetch_err, e.pc, e.cmd, e.err);
    end
    got = (acc_q.size() > 0) ? acc_q.pop_front() : 32'hDEAD_DEAD;
    n_cmp++;
    if (got !== 32'h8000_0000) begin n_bad++; $display("FAIL refetch_req: got %h want 80000000", got); end
  endtask

  task automatic test_linebuf();
    // step: 0 plain load, 1 reload, 2 flush pulse then load, 3 load with flush, 4 reload
    int   hit_lat;
    int   cyc;
    int   rc;
    int   want_lat;
    exp_t e;
`ifdef IFU_LINEBUF_EN
    hit_lat = 1;
`else
    hit_lat = 3;
`endif
    for (int s = 0; s < 5; s++) begin
      if (s == 2) begin
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
      end
      rc = req_count;
      do_load(32'h8000_0040, s == 3);
      want_lat = (s == 1 || s == 4) ? hit_lat : 3;
      wait_valid(cyc);
      n_cmp++;
      if (cyc !== want_lat) begin n_bad++; $display("FAIL linebuf_latency[%0d]: got %0d want %0d", s, cyc, want_lat); end
      e = exp_q.pop_front();
      n_cmp++;
      if ({pc, cmd, fetch_err} !== {e.pc, e.cmd, e.err}) begin
        n_bad++; $display("FAIL linebuf_fetch[%0d]: got pc=%h cmd=%h err=%b want pc=%h cmd=%h err=%b", s, pc, cmd, fetch_err, e.pc, e.cmd, e.err);
      end
      n_cmp++;
      if (req_count - rc !== (want_lat == 3 ? 1 : 0)) begin
        n_bad++; $display("FAIL linebuf_reqs[%0d]: got %0d want %0d", s, req_count - rc, (want_lat == 3 ? 1 : 0));
      end
      acc_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_ready_stall();
    test_misaligned();
    test_resp_err();
    test_back_to_back();
    test_reset_mid_wait();
    test_linebuf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
